mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have: ws_allowin in 1, WB can accept; ms_allowin out 1, MEM can accept.
REQ-003 SHALL have: es_to_ms_valid in 1; es_to_ms_bus in 110, {csr_data[33:0], ld_op[4:0], res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}.
REQ-004 SHALL have: es_mem_req in 1, the incoming instruction has a data-SRAM request (load or store) in flight.
REQ-005 SHALL have: data_sram_data_ok in 1, response strobe; data_sram_rdata in 32, read data.
REQ-006 SHALL have: ms_to_ws_valid out 1; ms_to_ws_bus out 104, {csr_data, gr_we, dest, final_result[31:0], pc}.
REQ-007 SHALL have: ms_fwd_valid out 1, ms_fwd_dest out 5, ms_fwd_data out 32, ms_fwd_stall out 1 (load result not yet available).
REQ-008 SHALL have: wb_ex in 1, exception/ertn flush from WB.

Function
REQ-009 ms_valid SHALL load es_to_ms_valid when ms_allowin=1; the bus and es_mem_req SHALL be latched only when es_to_ms_valid & ms_allowin.
REQ-010 ms_allowin SHALL be !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid SHALL be ms_valid & ms_ready_go & !wb_ex.
REQ-011 Response FSM states: IDLE (no request pending), WAIT (awaiting data_ok), HOLD (data captured, WB stalled).
REQ-012 IDLE->WAIT on acceptance with es_mem_req=1; WAIT->IDLE on data_ok & ws_allowin; WAIT->HOLD on data_ok & !ws_allowin; HOLD->IDLE on ws_allowin.
REQ-013 In HOLD, rdata SHALL come from a 32-bit capture register loaded on the data_ok cycle; in WAIT it SHALL come from data_sram_rdata directly (zero extra latency).
REQ-014 ms_ready_go SHALL be 1 in IDLE and HOLD, and data_ok in WAIT.
REQ-015 Acceptance into WAIT on the same cycle as leaving WAIT/HOLD SHALL be legal (back-to-back memory instructions).
REQ-016 Load extension by result[1:0]: ld_w word; ld_b/ld_bu select byte, sign/zero extend; ld_h/ld_hu select halfword at result[1], sign/zero extend; ld_op one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}.
REQ-017 final_result SHALL be the extended load data if res_from_mem, else result.
REQ-018 wb_ex SHALL clear ms_valid next cycle; if FSM in WAIT, a discard flag SHALL be set and the next data_ok dropped (not captured, not forwarded), FSM returning to IDLE.
REQ-019 While discard flag is set, ms_ready_go SHALL be 0 for any newly accepted memory instruction, and its own data_ok SHALL be recognised only after the discarded one.
REQ-020 ms_fwd_valid SHALL be ms_valid & gr_we & dest!=0; ms_fwd_data=final_result; ms_fwd_stall SHALL be ms_fwd_valid & res_from_mem & !ms_ready_go.
REQ-021 Stores (es_mem_req=1, res_from_mem=0) SHALL wait for data_ok like loads, forwarding result unchanged.

Reset
REQ-022 On reset: ms_valid=0, FSM=IDLE, discard flag=0, capture register=0; hence ms_to_ws_valid=0, ms_fwd_valid=0, ms_fwd_stall=0, ms_allowin=1.
REQ-023 Reset SHALL take priority over acceptance and data_ok on the same edge.

Structure
REQ-024 Bus widths (110, 104), field offsets, ld_op bit indices and FSM encodings SHALL live in a shared pipeline package used by EXE, MEM and WB stages.
REQ-025 Load extension SHALL be a combinational sub-module load_align(ld_op, addr_lo[1:0], rdata) -> data.

Verification
REQ-026 ld_b addr lo=3, rdata=0x80FF_1234, data_ok 2 cycles after accept -> ms_to_ws_valid on data_ok cycle, final_result=0xFFFF_FF80.
REQ-027 ld_hu addr lo=2, rdata=0x8001_0000, data_ok while ws_allowin=0 for 3 cycles -> FSM HOLD, result 0x0000_8001 delivered when ws_allowin rises.
REQ-028 Back-to-back ld_w, data_ok each cycle, ws_allowin=1 -> two WB transfers on consecutive cycles, no bubble.
REQ-029 wb_ex in WAIT, then new ld_w accepted, two data_ok pulses (0xDEAD_BEEF, 0x1234_5678) -> first dropped, new load result 0x1234_5678.
REQ-030 ALU op dest=5, result=0x42, es_mem_req=0 -> ms_fwd_valid=1, dest 5, data 0x42, ms_fwd_stall=0 same cycle; dest=0 -> ms_fwd_valid=0.
REQ-031 Assert reset in WAIT with data_ok same cycle -> all REQ-022 values next cycle, no WB transfer.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the EXE -> MEM -> WB stage boundary.
// Holds bus widths, field offsets of both inter-stage buses, the one-hot
// load-op bit indices and the MEM data-response FSM encoding.
package mem_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int CSR_W   = 34;
  localparam int DEST_W  = 5;
  localparam int LD_OP_W = 5;

  localparam int ES_TO_MS_BUS_W = 110;
  localparam int MS_TO_WS_BUS_W = 104;

  // es_to_ms_bus = {csr_data, ld_op, res_from_mem, gr_we, dest, result, pc}
  localparam int ES_PC_LSB           = 0;
  localparam int ES_RESULT_LSB       = 32;
  localparam int ES_DEST_LSB         = 64;
  localparam int ES_GR_WE_BIT        = 69;
  localparam int ES_RES_FROM_MEM_BIT = 70;
  localparam int ES_LD_OP_LSB        = 71;
  localparam int ES_CSR_LSB          = 76;

  // ms_to_ws_bus = {csr_data, gr_we, dest, final_result, pc}
  localparam int MS_PC_LSB     = 0;
  localparam int MS_RESULT_LSB = 32;
  localparam int MS_DEST_LSB   = 64;
  localparam int MS_GR_WE_BIT  = 69;
  localparam int MS_CSR_LSB    = 70;

  // ld_op one-hot = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_W_BIT  = 0;
  localparam int LD_HU_BIT = 1;
  localparam int LD_H_BIT  = 2;
  localparam int LD_BU_BIT = 3;
  localparam int LD_B_BIT  = 4;

  // Data-SRAM response tracking in MEM
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,  // no request pending
    RSP_WAIT = 2'd1,  // awaiting data_ok
    RSP_HOLD = 2'd2   // response captured, WB stalled
  } rsp_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data extraction and extension.
// Ports:
//   ld_op   - one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   addr_lo - low two address bits, selects byte / halfword lane
//   rdata   - raw 32-bit word from the data SRAM
//   data    - aligned, sign- or zero-extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  data
);

  logic signed [7:0]        byte_sel;
  logic signed [15:0]       half_sel;
  logic signed [DATA_W-1:0] byte_sx;
  logic signed [DATA_W-1:0] half_sx;
  logic        [DATA_W-1:0] byte_zx;
  logic        [DATA_W-1:0] half_zx;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  assign byte_sx = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
  assign half_sx = {{(DATA_W-16){half_sel[15]}}, half_sel};
  assign byte_zx = {{(DATA_W-8){1'b0}}, byte_sel};
  assign half_zx = {{(DATA_W-16){1'b0}}, half_sel};

  // ld_w (and a non-load op) pass the word through untouched
  always_comb begin
    data = rdata;
    if (ld_op[LD_B_BIT])       data = byte_sx;
    else if (ld_op[LD_BU_BIT]) data = byte_zx;
    else if (ld_op[LD_H_BIT])  data = half_sx;
    else if (ld_op[LD_HU_BIT]) data = half_zx;
    else if (ld_op[LD_W_BIT])  data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-SRAM response tracking.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   ws_allowin / ms_allowin   - WB can accept / MEM can accept
//   es_to_ms_valid, _bus      - instruction from EXE (110-bit bus)
//   es_mem_req                - incoming instruction has a data-SRAM request
//   data_sram_data_ok, _rdata - data-SRAM response strobe and read data
//   ms_to_ws_valid, _bus      - instruction to WB (104-bit bus)
//   ms_fwd_*                  - forwarding valid/dest/data and load-use stall
//   wb_ex                     - exception/ertn flush from WB
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ws_allowin,
  output logic                      ms_allowin,
  input  logic                      es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  input  logic                      es_mem_req,
  input  logic                      data_sram_data_ok,
  input  logic [DATA_W-1:0]         data_sram_rdata,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
  output logic                      ms_fwd_valid,
  output logic [DEST_W-1:0]         ms_fwd_dest,
  output logic [DATA_W-1:0]         ms_fwd_data,
  output logic                      ms_fwd_stall,
  input  logic                      wb_ex
);

  logic                      ms_valid;
  logic [ES_TO_MS_BUS_W-1:0] ms_bus;
  logic                      ms_ready_go;
  logic                      load_bus;
  logic                      accept;
  logic                      mem_accept;

  rsp_state_t                state;
  rsp_state_t                state_nxt;
  logic [1:0]                discard_cnt;
  logic [1:0]                discard_nxt;
  logic                      discard;
  logic                      discard_set;
  logic                      discard_clr;
  logic                      own_ok;
  logic [DATA_W-1:0]         cap_data;
  logic [DATA_W-1:0]         mem_rdata;
  logic [DATA_W-1:0]         ld_data;

  logic [CSR_W-1:0]          ms_csr_data;
  logic [LD_OP_W-1:0]        ms_ld_op;
  logic                      ms_res_from_mem;
  logic                      ms_gr_we;
  logic [DEST_W-1:0]         ms_dest;
  logic [DATA_W-1:0]         ms_result;
  logic [DATA_W-1:0]         ms_pc;
  logic [DATA_W-1:0]         final_result;

  // ---- Stage boundary: EXE -> MEM register ----
  assign load_bus   = es_to_ms_valid & ms_allowin;
  // A flush from WB also kills whatever EXE is offering this cycle
  assign accept     = load_bus & ~wb_ex;
  assign mem_accept = accept & es_mem_req;

  always_ff @(posedge clk) begin
    if (reset)           ms_valid <= 1'b0;
    else if (wb_ex)      ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (load_bus) ms_bus <= es_to_ms_bus;
  end

  assign ms_csr_data     = ms_bus[ES_CSR_LSB +: CSR_W];
  assign ms_ld_op        = ms_bus[ES_LD_OP_LSB +: LD_OP_W];
  assign ms_res_from_mem = ms_bus[ES_RES_FROM_MEM_BIT];
  assign ms_gr_we        = ms_bus[ES_GR_WE_BIT];
  assign ms_dest         = ms_bus[ES_DEST_LSB +: DEST_W];
  assign ms_result       = ms_bus[ES_RESULT_LSB +: DATA_W];
  assign ms_pc           = ms_bus[ES_PC_LSB +: DATA_W];

  // Responses owed to flushed instructions arrive first and must be
  // swallowed before the current instruction's data_ok is believed.
  assign discard     = (discard_cnt != 2'd0);
  assign own_ok      = data_sram_data_ok & ~discard;
  assign discard_set = (state == RSP_WAIT) & wb_ex & ~own_ok;
  assign discard_clr = data_sram_data_ok & discard;

  always_comb begin
    discard_nxt = discard_cnt;
    if (discard_set && !discard_clr)      discard_nxt = discard_cnt + 2'd1;
    else if (!discard_set && discard_clr) discard_nxt = discard_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) discard_cnt <= 2'd0;
    else       discard_cnt <= discard_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RSP_IDLE;
    else       state <= state_nxt;
  end

  // Leaving WAIT/HOLD and accepting the next memory op share one edge
  always_comb begin
    state_nxt = state;
    case (state)
      RSP_IDLE: begin
        if (mem_accept) state_nxt = RSP_WAIT;
      end
      RSP_WAIT: begin
        if (wb_ex)              state_nxt = RSP_IDLE;
        else if (own_ok) begin
          if (!ws_allowin)      state_nxt = RSP_HOLD;
          else if (mem_accept)  state_nxt = RSP_WAIT;
          else                  state_nxt = RSP_IDLE;
        end
      end
      RSP_HOLD: begin
        if (wb_ex)              state_nxt = RSP_IDLE;
        else if (ws_allowin)    state_nxt = mem_accept ? RSP_WAIT : RSP_IDLE;
      end
      default:                  state_nxt = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                              cap_data <= '0;
    else if ((state == RSP_WAIT) && own_ok) cap_data <= data_sram_rdata;
  end

  always_comb begin
    ms_ready_go = 1'b1;
    if (state == RSP_WAIT) ms_ready_go = own_ok;
  end

  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_ex;

  // ---- Stage boundary: MEM result -> WB bus ----
  assign mem_rdata = (state == RSP_HOLD) ? cap_data : data_sram_rdata;

  load_align u_load_align (
    .ld_op   (ms_ld_op),
    .addr_lo (ms_result[1:0]),
    .rdata   (mem_rdata),
    .data    (ld_data)
  );

  assign final_result = ms_res_from_mem ? ld_data : ms_result;

  always_comb begin
    ms_to_ws_bus                               = '0;
    ms_to_ws_bus[MS_CSR_LSB +: CSR_W]          = ms_csr_data;
    ms_to_ws_bus[MS_GR_WE_BIT]                 = ms_gr_we;
    ms_to_ws_bus[MS_DEST_LSB +: DEST_W]        = ms_dest;
    ms_to_ws_bus[MS_RESULT_LSB +: DATA_W]      = final_result;
    ms_to_ws_bus[MS_PC_LSB +: DATA_W]          = ms_pc;
  end

  assign ms_fwd_valid = ms_valid & ms_gr_we & (ms_dest != '0);
  assign ms_fwd_dest  = ms_dest;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_stall = ms_fwd_valid & ms_res_from_mem & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: load extension, response FSM,
// back-to-back loads, flush discard, forwarding, stores and reset.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [109:0] es_to_ms_bus;
  logic         es_mem_req;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [103:0] ms_to_ws_bus;
  logic         ms_fwd_valid;
  logic [4:0]   ms_fwd_dest;
  logic [31:0]  ms_fwd_data;
  logic         ms_fwd_stall;
  logic         wb_ex;

  localparam logic [33:0] CSR   = 34'h1_2345_6789;
  localparam logic [4:0]  OP_B  = 5'b10000;
  localparam logic [4:0]  OP_BU = 5'b01000;
  localparam logic [4:0]  OP_H  = 5'b00100;
  localparam logic [4:0]  OP_HU = 5'b00010;
  localparam logic [4:0]  OP_W  = 5'b00001;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_mem_req        (es_mem_req),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_valid      (ms_fwd_valid),
    .ms_fwd_dest       (ms_fwd_dest),
    .ms_fwd_data       (ms_fwd_data),
    .ms_fwd_stall      (ms_fwd_stall),
    .wb_ex             (wb_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [109:0] mk_bus(input logic [4:0] op, input logic rfm, input logic we,
                                          input logic [4:0] dst, input logic [31:0] res,
                                          input logic [31:0] pc);
    return {CSR, op, rfm, we, dst, res, pc};
  endfunction

  function automatic logic [103:0] ws_bus(input logic we, input logic [4:0] dst,
                                          input logic [31:0] fr, input logic [31:0] pc);
    return {CSR, we, dst, fr, pc};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_in;
    es_to_ms_valid    = 1'b0;
    es_mem_req        = 1'b0;
    data_sram_data_ok = 1'b0;
    wb_ex             = 1'b0;
  endtask

  task automatic issue(input logic [109:0] bus, input logic mem);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    es_mem_req     = mem;
  endtask

  // Single load: accept, data_ok on the next cycle, check the WB bus
  task automatic do_load(input string tag, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(mk_bus(op, 1'b1, 1'b1, 5'd7, addr, 32'h0000_0800), 1'b1);
    settle;
    check({tag, "_allowin"}, 128'(ms_allowin), 128'(1));
    next_cycle;
    idle_in;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle;
    check({tag, "_valid"}, 128'(ms_to_ws_valid), 128'(1));
    check({tag, "_bus"}, 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd7, exp, 32'h0000_0800)));
    next_cycle;
    idle_in;
    data_sram_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_bus    = '0;
    data_sram_rdata = 32'h0;
    idle_in;
    next_cycle;
    next_cycle;
    settle;
    check("rst_allowin", 128'(ms_allowin), 128'(1));
    check("rst_valid", 128'(ms_to_ws_valid), 128'(0));
    check("rst_fwd_valid", 128'(ms_fwd_valid), 128'(0));
    check("rst_fwd_stall", 128'(ms_fwd_stall), 128'(0));
    reset = 1'b0;
    next_cycle;

    // ld_b at byte 3, data_ok two cycles after acceptance
    issue(mk_bus(OP_B, 1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'h0000_1000), 1'b1);
    settle;
    check("t1_allowin", 128'(ms_allowin), 128'(1));
    next_cycle;
    idle_in;
    settle;
    check("t1_wait_valid", 128'(ms_to_ws_valid), 128'(0));
    check("t1_wait_stall", 128'(ms_fwd_stall), 128'(1));
    check("t1_wait_allowin", 128'(ms_allowin), 128'(0));
    next_cycle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    settle;
    check("t1_ok_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t1_ok_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd4, 32'hFFFF_FF80, 32'h0000_1000)));
    check("t1_ok_fwd_data", 128'(ms_fwd_data), 128'(32'hFFFF_FF80));
    check("t1_ok_stall", 128'(ms_fwd_stall), 128'(0));
    next_cycle;
    idle_in;
    settle;
    check("t1_after_valid", 128'(ms_to_ws_valid), 128'(0));
    check("t1_after_allowin", 128'(ms_allowin), 128'(1));
    next_cycle;

    // ld_hu at halfword 2, WB stalled for three cycles -> HOLD
    issue(mk_bus(OP_HU, 1'b1, 1'b1, 5'd6, 32'h0000_2002, 32'h0000_2000), 1'b1);
    next_cycle;
    idle_in;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    settle;
    check("t2_ok_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t2_ok_allowin", 128'(ms_allowin), 128'(0));
    next_cycle;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hFFFF_FFFF;
    settle;
    check("t2_hold1_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t2_hold1_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd6, 32'h0000_8001, 32'h0000_2000)));
    next_cycle;
    settle;
    check("t2_hold2_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd6, 32'h0000_8001, 32'h0000_2000)));
    next_cycle;
    ws_allowin = 1'b1;
    settle;
    check("t2_rel_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t2_rel_allowin", 128'(ms_allowin), 128'(1));
    check("t2_rel_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd6, 32'h0000_8001, 32'h0000_2000)));
    next_cycle;
    data_sram_rdata = 32'h0;
    settle;
    check("t2_after_valid", 128'(ms_to_ws_valid), 128'(0));
    next_cycle;

    // Back-to-back ld_w, data_ok each cycle
    issue(mk_bus(OP_W, 1'b1, 1'b1, 5'd8, 32'h0000_3000, 32'h0000_0100), 1'b1);
    next_cycle;
    issue(mk_bus(OP_W, 1'b1, 1'b1, 5'd9, 32'h0000_3004, 32'h0000_0104), 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    settle;
    check("t3_first_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t3_first_allowin", 128'(ms_allowin), 128'(1));
    check("t3_first_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd8, 32'h1111_1111, 32'h0000_0100)));
    next_cycle;
    idle_in;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    settle;
    check("t3_second_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t3_second_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd9, 32'h2222_2222, 32'h0000_0104)));
    next_cycle;
    idle_in;
    settle;
    check("t3_after_valid", 128'(ms_to_ws_valid), 128'(0));
    next_cycle;

    // Flush while waiting, then a new load sees the stale response dropped
    issue(mk_bus(OP_W, 1'b1, 1'b1, 5'd10, 32'h0000_4000, 32'h0000_0300), 1'b1);
    next_cycle;
    idle_in;
    wb_ex = 1'b1;
    settle;
    check("t4_flush_valid", 128'(ms_to_ws_valid), 128'(0));
    next_cycle;
    wb_ex = 1'b0;
    issue(mk_bus(OP_W, 1'b1, 1'b1, 5'd11, 32'h0000_4004, 32'h0000_0200), 1'b1);
    settle;
    check("t4_new_allowin", 128'(ms_allowin), 128'(1));
    next_cycle;
    idle_in;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    settle;
    check("t4_stale_valid", 128'(ms_to_ws_valid), 128'(0));
    check("t4_stale_stall", 128'(ms_fwd_stall), 128'(1));
    next_cycle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    settle;
    check("t4_own_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t4_own_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b1, 5'd11, 32'h1234_5678, 32'h0000_0200)));
    next_cycle;
    idle_in;
    settle;
    check("t4_after_valid", 128'(ms_to_ws_valid), 128'(0));
    next_cycle;

    // ALU op forwarding, then dest=0 is not forwarded
    issue(mk_bus(5'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0042, 32'h0000_0500), 1'b0);
    next_cycle;
    issue(mk_bus(5'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0099, 32'h0000_0504), 1'b0);
    settle;
    check("t5_fwd_valid", 128'(ms_fwd_valid), 128'(1));
    check("t5_fwd_dest", 128'(ms_fwd_dest), 128'(5));
    check("t5_fwd_data", 128'(ms_fwd_data), 128'(32'h42));
    check("t5_fwd_stall", 128'(ms_fwd_stall), 128'(0));
    check("t5_valid", 128'(ms_to_ws_valid), 128'(1));
    next_cycle;
    idle_in;
    settle;
    check("t5_d0_fwd_valid", 128'(ms_fwd_valid), 128'(0));
    check("t5_d0_valid", 128'(ms_to_ws_valid), 128'(1));
    next_cycle;
    settle;
    check("t5_after_valid", 128'(ms_to_ws_valid), 128'(0));

    // Store waits for data_ok and passes result through
    issue(mk_bus(5'b0, 1'b0, 1'b0, 5'd0, 32'h1000_0008, 32'h0000_0600), 1'b1);
    next_cycle;
    idle_in;
    settle;
    check("t6_wait_valid", 128'(ms_to_ws_valid), 128'(0));
    check("t6_wait_allowin", 128'(ms_allowin), 128'(0));
    next_cycle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hFFFF_FFFF;
    settle;
    check("t6_ok_valid", 128'(ms_to_ws_valid), 128'(1));
    check("t6_ok_bus", 128'(ms_to_ws_bus), 128'(ws_bus(1'b0, 5'd0, 32'h1000_0008, 32'h0000_0600)));
    next_cycle;
    idle_in;
    data_sram_rdata = 32'h0;

    // Remaining extension cases
    do_load("t7_h_neg", OP_H, 32'h0000_5000, 32'h1234_F00D, 32'hFFFF_F00D);
    do_load("t7_bu_1", OP_BU, 32'h0000_5001, 32'h0000_8000, 32'h0000_0080);
    do_load("t7_h_hi", OP_H, 32'h0000_5002, 32'h7FFF_0000, 32'h0000_7FFF);
    do_load("t7_b_pos", OP_B, 32'h0000_5004, 32'h0000_007F, 32'h0000_007F);
    do_load("t7_hu_lo", OP_HU, 32'h0000_5008, 32'h0000_F00D, 32'h0000_F00D);
    do_load("t7_w", OP_W, 32'h0000_500C, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

    // Reset in WAIT with data_ok on the same edge
    issue(mk_bus(OP_W, 1'b1, 1'b1, 5'd12, 32'h0000_6000, 32'h0000_0700), 1'b1);
    next_cycle;
    idle_in;
    reset             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_AAAA;
    next_cycle;
    reset             = 1'b0;
    data_sram_data_ok = 1'b0;
    settle;
    check("t8_allowin", 128'(ms_allowin), 128'(1));
    check("t8_valid", 128'(ms_to_ws_valid), 128'(0));
    check("t8_fwd_valid", 128'(ms_fwd_valid), 128'(0));
    check("t8_fwd_stall", 128'(ms_fwd_stall), 128'(0));
    next_cycle;
    do_load("t8_post", OP_W, 32'h0000_6004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
